// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mode controller for the 4-digit BCD stopwatch datapath.
//
// Sequences IDLE / RUN / PAUSE / SET from single-cycle debounced key pulses.
// It drives the datapath run level, a clear pulse and per-digit increment
// pulses. It also drives the digit-select and blink-blank masks for the hex
// display.
//
// Ports
//   clk100_i           in   1  system clock, 100 MHz
//   rstn_i             in   1  asynchronous active-low reset
//   start_stop_down_i  in   1  one-cycle press pulse, start/stop key
//   set_down_i         in   1  one-cycle press pulse, set key
//   change_down_i      in   1  one-cycle press pulse, change key
//   run_o              out  1  level, datapath counters advance while 1 (RUN only)
//   clear_o            out  1  one-cycle pulse, datapath zeroes all digits
//   inc_o              out  4  one-cycle one-hot pulse, digit k += 1 mod 10
//   sel_o              out  4  one-hot digit under edit, 4'b0000 outside SET
//   blank_o            out  4  digits to blank in the current blink phase (subset of sel_o)
//   state_o            out  2  IDLE=0, RUN=1, PAUSE=2, SET=3
//
// Every output is a function of registered state only. A press sampled at
// one edge is visible right after that edge.

module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV      = 1000000, // clk cycles per 10 ms tick
  parameter int unsigned BLINK_TICKS   = 25,      // ticks per blink half-period
  parameter int unsigned TIMEOUT_TICKS = 1000     // idle ticks in SET before auto-exit
) (
  input  logic       clk100_i,
  input  logic       rstn_i,
  input  logic       start_stop_down_i,
  input  logic       set_down_i,
  input  logic       change_down_i,
  output logic       run_o,
  output logic       clear_o,
  output logic [3:0] inc_o,
  output logic [3:0] sel_o,
  output logic [3:0] blank_o,
  output logic [1:0] state_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StPause = 2'd2;
  localparam logic [1:0] StSet   = 2'd3;

  localparam int unsigned PW = $clog2(TICK_DIV) + 1;
  localparam int unsigned BW = $clog2(BLINK_TICKS) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS) + 1;

  localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_TICKS - 1);
  localparam logic [TW-1:0] ToLimit   = TW'(TIMEOUT_TICKS);

  // State registers
  logic [1:0]    state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic          clear_q, clear_d;
  logic [3:0]    inc_q, inc_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;   // 1 = blank half of the blink period
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic       tick;
  logic       any_press;
  logic [3:0] ptr_onehot;

  // Prescaler free-runs in every state; tick marks its terminal count.
  assign tick    = (presc_q == PrescLast);
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  assign any_press  = start_stop_down_i | set_down_i | change_down_i;
  assign ptr_onehot = 4'b0001 << ptr_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    clear_d     = 1'b0;
    inc_d       = 4'b0000;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    to_cnt_d    = to_cnt_q;

    case (state_q)
      StIdle: begin
        if (start_stop_down_i) begin
          state_d = StRun;
        end else if (set_down_i) begin
          state_d = StSet;
        end
      end

      StRun: begin
        if (start_stop_down_i) begin
          state_d = StPause;
        end
      end

      StPause: begin
        if (start_stop_down_i) begin
          state_d = StRun;
        end else if (set_down_i) begin
          state_d = StSet;
        end else if (change_down_i) begin
          clear_d = 1'b1;
          state_d = StIdle;
        end
      end

      StSet: begin
        if (tick) begin
          if (blink_cnt_q == BlinkLast) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
          // Saturate; the compare below exits SET before it could wrap.
          if (to_cnt_q != ToLimit) begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end

        if (start_stop_down_i) begin
          state_d = StPause;
        end else if (set_down_i) begin
          if (ptr_q == 2'd3) begin
            state_d = StPause;
          end else begin
            ptr_d       = ptr_q + 2'd1;
            // Newly selected digit starts in the visible phase.
            blink_cnt_d = '0;
            phase_d     = 1'b0;
          end
        end else if (change_down_i) begin
          inc_d = ptr_onehot;
        end else if (to_cnt_q == ToLimit) begin
          state_d = StPause;
        end

        // Any pulse restarts the inactivity window, including dropped ones.
        if (any_press) begin
          to_cnt_d = '0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Edit context exists only while staying in SET. Both SET entry and
    // SET exit start from a clean pointer, blink phase and timeout count.
    if ((state_d != StSet) || (state_q != StSet)) begin
      ptr_d       = 2'd0;
      blink_cnt_d = '0;
      phase_d     = 1'b0;
      to_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      ptr_q       <= 2'd0;
      clear_q     <= 1'b0;
      inc_q       <= 4'b0000;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      clear_q     <= clear_d;
      inc_q       <= inc_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  // Outputs decode registered state only, so reset takes effect at once.
  assign state_o = state_q;
  assign run_o   = (state_q == StRun);
  assign clear_o = clear_q;
  assign inc_o   = inc_q;
  assign sel_o   = (state_q == StSet) ? ptr_onehot : 4'b0000;
  assign blank_o = phase_q ? sel_o : 4'b0000;

`ifndef SYNTHESIS
  a_inc_clear_excl : assert property (@(posedge clk100_i) disable iff (!rstn_i)
    !(clear_o && (inc_o != 4'b0000)));
  a_blank_subset : assert property (@(posedge clk100_i) disable iff (!rstn_i)
    ((blank_o & ~sel_o) == 4'b0000));
  a_sel_onehot0 : assert property (@(posedge clk100_i) disable iff (!rstn_i)
    $onehot0(sel_o));
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl. It uses a short tick (TICK_DIV=4,
// BLINK_TICKS=2, TIMEOUT_TICKS=8), so blink and timeout behaviour fit in a
// few dozen cycles.
module tb_stopwatch_ctrl;

  logic       clk100_i = 1'b0;
  logic       rstn_i   = 1'b0;
  logic       start_stop_down_i = 1'b0;
  logic       set_down_i        = 1'b0;
  logic       change_down_i     = 1'b0;
  logic       run_o;
  logic       clear_o;
  logic [3:0] inc_o;
  logic [3:0] sel_o;
  logic [3:0] blank_o;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(
    .TICK_DIV      (4),
    .BLINK_TICKS   (2),
    .TIMEOUT_TICKS (8)
  ) u_dut (
    .clk100_i          (clk100_i),
    .rstn_i            (rstn_i),
    .start_stop_down_i (start_stop_down_i),
    .set_down_i        (set_down_i),
    .change_down_i     (change_down_i),
    .run_o             (run_o),
    .clear_o           (clear_o),
    .inc_o             (inc_o),
    .sel_o             (sel_o),
    .blank_o           (blank_o),
    .state_o           (state_o)
  );

  always #5 clk100_i = ~clk100_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one pulse set for exactly one rising edge, then sample 1 ns later.
  task automatic press(input logic ss, input logic st, input logic ch);
    start_stop_down_i = ss;
    set_down_i        = st;
    change_down_i     = ch;
    @(posedge clk100_i);
    #1;
    start_stop_down_i = 1'b0;
    set_down_i        = 1'b0;
    change_down_i     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk100_i);
      #1;
    end
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk100_i);
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_run",   32'(run_o),   32'd0);
    check("rst_clear", 32'(clear_o), 32'd0);
    check("rst_inc",   32'(inc_o),   32'd0);
    check("rst_sel",   32'(sel_o),   32'd0);
    check("rst_blank", 32'(blank_o), 32'd0);
    @(negedge clk100_i);
    rstn_i = 1'b1;
    idle(2);
    check("idle_state", 32'(state_o), 32'd0);

    // 1: start / stop
    press(1'b1, 1'b0, 1'b0);
    check("t1_run_state", 32'(state_o), 32'd1);
    check("t1_run_run",   32'(run_o),   32'd1);
    press(1'b1, 1'b0, 1'b0);
    check("t1_pause_state", 32'(state_o), 32'd2);
    check("t1_pause_run",   32'(run_o),   32'd0);

    // 2: clear from PAUSE
    press(1'b0, 1'b0, 1'b1);
    check("t2_clear_hi", 32'(clear_o), 32'd1);
    check("t2_state",    32'(state_o), 32'd0);
    check("t2_run",      32'(run_o),   32'd0);
    check("t2_inc",      32'(inc_o),   32'd0);
    idle(1);
    check("t2_clear_lo", 32'(clear_o), 32'd0);
    check("t2_state2",   32'(state_o), 32'd0);

    // 3: edit digits from IDLE
    press(1'b0, 1'b1, 1'b0);
    check("t3_state", 32'(state_o), 32'd3);
    check("t3_sel0",  32'(sel_o),   32'b0001);
    check("t3_run",   32'(run_o),   32'd0);
    press(1'b0, 1'b0, 1'b1);
    check("t3_inc0a", 32'(inc_o), 32'b0001);
    idle(1);
    check("t3_inc_lo1", 32'(inc_o), 32'd0);
    press(1'b0, 1'b0, 1'b1);
    check("t3_inc0b", 32'(inc_o), 32'b0001);
    press(1'b0, 1'b1, 1'b0);
    check("t3_sel1",   32'(sel_o), 32'b0010);
    check("t3_inc_lo2", 32'(inc_o), 32'd0);
    press(1'b0, 1'b0, 1'b1);
    check("t3_inc1",    32'(inc_o),   32'b0010);
    check("t3_state2",  32'(state_o), 32'd3);
    idle(1);
    check("t3_inc_lo3", 32'(inc_o), 32'd0);

    // set beats change in the same cycle
    press(1'b0, 1'b1, 1'b1);
    check("prio_sel2", 32'(sel_o), 32'b0100);
    check("prio_inc",  32'(inc_o), 32'd0);
    press(1'b0, 1'b1, 1'b0);
    check("t4_sel3", 32'(sel_o), 32'b1000);

    // 4: leave SET from the last digit, then start_stop beats set
    press(1'b0, 1'b1, 1'b0);
    check("t4_state", 32'(state_o), 32'd2);
    check("t4_sel",   32'(sel_o),   32'd0);
    check("t4_blank", 32'(blank_o), 32'd0);
    press(1'b1, 1'b1, 1'b0);
    check("t4_prio_state", 32'(state_o), 32'd1);
    check("t4_prio_run",   32'(run_o),   32'd1);
    check("t4_prio_sel",   32'(sel_o),   32'd0);

    // 6: set/change ignored in RUN, async reset mid-RUN
    press(1'b0, 1'b1, 1'b0);
    check("t6_set_state", 32'(state_o), 32'd1);
    check("t6_set_sel",   32'(sel_o),   32'd0);
    press(1'b0, 1'b0, 1'b1);
    check("t6_chg_inc",   32'(inc_o),   32'd0);
    check("t6_chg_clear", 32'(clear_o), 32'd0);
    check("t6_chg_sel",   32'(sel_o),   32'd0);
    check("t6_chg_run",   32'(run_o),   32'd1);
    #2;
    rstn_i = 1'b0;
    #1;
    check("t6_rst_run",   32'(run_o),   32'd0);
    check("t6_rst_state", 32'(state_o), 32'd0);

    // 5: blink and timeout. The prescaler is zero at release, so ticks land
    // on edges 4, 8, 12, ... counted from the release.
    @(negedge clk100_i);
    rstn_i     = 1'b1;
    set_down_i = 1'b1;
    @(posedge clk100_i);   // edge 1: enter SET
    #1;
    set_down_i = 1'b0;
    check("t5_state", 32'(state_o), 32'd3);
    check("t5_sel",   32'(sel_o),   32'b0001);
    check("t5_blank0", 32'(blank_o), 32'd0);
    idle(6);               // edge 7
    check("t5_blank_e7", 32'(blank_o), 32'd0);
    idle(1);               // edge 8
    check("t5_blank_e8", 32'(blank_o), 32'b0001);
    idle(7);               // edge 15
    check("t5_blank_e15", 32'(blank_o), 32'b0001);
    idle(1);               // edge 16
    check("t5_blank_e16", 32'(blank_o), 32'd0);
    idle(8);               // edge 24
    check("t5_blank_e24", 32'(blank_o), 32'b0001);
    idle(8);               // edge 32
    check("t5_state_e32", 32'(state_o), 32'd3);
    idle(1);               // edge 33: timeout fires
    check("t5_to_state", 32'(state_o), 32'd2);
    check("t5_to_sel",   32'(sel_o),   32'd0);
    check("t5_to_blank", 32'(blank_o), 32'd0);

    // start_stop in SET returns to PAUSE without counting
    press(1'b0, 1'b1, 1'b0);
    check("ss_set_state", 32'(state_o), 32'd3);
    press(1'b1, 1'b0, 1'b0);
    check("ss_exit_state", 32'(state_o), 32'd2);
    check("ss_exit_run",   32'(run_o),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
